pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised, handshaked pipeline stage register: the general-purpose successor to the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field and a data field from one stage to the next, with valid/ready flow control and a 2-entry skid buffer so `in_ready` never depends combinationally on `out_ready`. It also supports a synchronous flush (bubble insertion), a global halt freeze, and a saturating back-pressure counter for performance debug. It sits between any two core stages; the EX→MEM instance is the first user.

## Interface
- `CTRL_W`, default 16: width of the control field (valid-qualifying bits such as re/we/use_dst_reg). This field is always cleared on reset and flush.
- `DATA_W`, default 128: width of the data field (PC, ALU result, store data, etc.).
- `CLR_DATA`, default 1: if 1, the data field is also cleared on flush. If 0, data holds its old value on flush (saves area).
- `CNT_W`, default 16: width of the stall counter.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous flush; kills all held entries.
- `hlt` in 1: global halt; freezes all state.
- `in_valid` in 1: upstream entry valid.
- `in_ready` out 1: stage can accept an entry this cycle.
- `in_ctrl` in CTRL_W: upstream control field.
- `in_data` in DATA_W: upstream data field.
- `out_valid` out 1: downstream entry valid.
- `out_ready` in 1: downstream accepts.
- `out_ctrl` out CTRL_W: registered control field.
- `out_data` out DATA_W: registered data field.
- `stall_cnt` out CNT_W: saturating count of back-pressure cycles.
- `stall_clr` in 1: synchronous clear of `stall_cnt`.

## Operation
- Storage consists of two entries:
  - main entry: drives the outputs.
  - skid entry: catches an accepted input while main is blocked.
- Occupancy states:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main valid, skid valid.
- Handshake signals:
  - `in_ready = !skid_valid & !hlt`. It depends on registered state and `hlt` only.
  - `out_valid = main_valid & !hlt`.
  - Input transfer: `in_valid & in_ready`.
  - Output transfer: `out_valid & out_ready`.
- Transitions, evaluated when `flush=0` and `hlt=0`:
  - EMPTY + in xfer → ONE. Input is loaded into main.
  - ONE + in xfer + out xfer → ONE. Main is replaced by the input.
  - ONE + in xfer, no out xfer → FULL. Input is loaded into skid.
  - ONE + out xfer only → EMPTY.
  - FULL + out xfer → ONE. Skid moves to main. No input is accepted, because `in_ready=0`.
  - Any other combination → hold.
- Order is strictly FIFO. No entry is duplicated or dropped except on flush.
- Flush:
  - Highest priority after reset.
  - Clears both valid bits and both ctrl fields to 0. Data fields are cleared only when `CLR_DATA=1`.
  - An input presented in the flush cycle is discarded, even if `in_ready` was high.
  - The state is EMPTY on the next cycle.
- Halt:
  - Applies when `flush=0`.
  - All registers hold, including `stall_cnt`.
  - `in_ready` and `out_valid` are forced to 0, so no transfers occur.
  - Flush overrides halt.
- Stall counter:
  - Increments by 1 each cycle with `main_valid & !out_ready & !hlt & !flush`.
  - Saturates at 2^CNT_W−1.
  - `stall_clr` takes priority over increment.
- Outputs are taken from the main entry registers only. No combinational path exists from `in_*` to `out_*`.

## Timing
- Reset values: `out_valid=0`, `out_ctrl=0`, `out_data=0`, `stall_cnt=0`, internal skid valid=0. Therefore `in_ready=!hlt` during and right after reset.
- Latency: an entry accepted at edge N appears on `out_*` after edge N, i.e. 1 cycle.
- Throughput: 1 entry per cycle when `out_ready` is held at 1. The skid entry stays unused in that case.
- Back-pressure: `in_ready` falls 1 cycle after the first blocked cycle with a new input (the ONE→FULL transition). It rises the cycle after the next out xfer.
- Reset asserted mid-operation clears all state immediately, asynchronously. In-flight entries are lost.
- Flush and `stall_clr` act at the next rising edge.

## Structure
- Shared package `pipe_pkg` holds:
  - occupancy state encoding (EMPTY/ONE/FULL localparams);
  - a saturating-increment function used by every stall counter in the core.
- Sub-module `pipe_entry`:
  - one valid + ctrl + data register with load, clear, and `CLR_DATA` handling.
  - Instantiated twice, as main and skid.
- The top level contains the occupancy control logic, the handshake logic, and the stall counter.

## Test plan
- Reset, then `in_valid=1` with ctrl=0x0003 and data=0xA5 at one edge, `out_ready=1` → the next cycle shows `out_valid=1`, `out_ctrl=0x0003`, `out_data=0xA5`. On the cycle after, `out_valid=0`.
- Stream values 1..8 with `out_ready=1` → outputs 1..8 appear on consecutive cycles, `in_ready` stays 1, and `stall_cnt` stays 0.
- Send 1, 2, 3 with `out_ready=0` → `in_ready=0` after 2 is accepted and 3 is held upstream. Then set `out_ready=1` → outputs 1, 2, 3 in order, and `stall_cnt` equals the number of blocked cycles.
- In state FULL (holding 5, 6), assert `flush` with `in_valid=1` and data 7 → the next cycle has `out_valid=0` and `out_ctrl=0`, and 7 never appears. With `CLR_DATA=1`, `out_data=0`.
- Assert `hlt` for 4 cycles in state ONE (holding 9) → `in_ready=0`, `out_valid=0`, and `stall_cnt` is unchanged. After release, 9 is delivered exactly once.
- With `CNT_W=4`, hold back-pressure for 20 cycles → `stall_cnt` saturates at 15. Then pulse `stall_clr` → `stall_cnt=0` on the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: occupancy encoding for handshaked stage
// registers and the saturating increment used by the stall counters.
package pipe_pkg;

    // Encoded as {skid_valid, main_valid}; 2'b10 cannot occur.
    localparam logic [1:0] OCC_EMPTY = 2'b00;
    localparam logic [1:0] OCC_ONE   = 2'b01;
    localparam logic [1:0] OCC_FULL  = 2'b11;

    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? max_val : (val + 64'd1);
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: valid + ctrl + data with load, valid-drop and clear.
// Clear always zeroes ctrl; data is zeroed only when CLR_DATA is set.
module pipe_entry #(
    parameter int CTRL_W   = 16,
    parameter int DATA_W   = 128,
    parameter int CLR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic              drop_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            if (CLR_DATA != 0) begin
                data_q <= '0;
            end
        end else if (ld_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end else if (drop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a 2-entry skid buffer, flush,
// halt and a saturating back-pressure counter. Outputs come from main only.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = 16,
    parameter int DATA_W   = 128,
    parameter int CLR_DATA = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              hlt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_xfer, out_xfer;
    logic              main_ld, main_from_skid, main_drop, skid_ld, skid_drop;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // Halt gates both handshakes, so every transition below sees no transfer.
    assign in_ready  = !skid_valid && !hlt;
    assign out_valid = main_valid && !hlt;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        main_drop      = 1'b0;
        skid_ld        = 1'b0;
        skid_drop      = 1'b0;
        case ({skid_valid, main_valid})
            OCC_EMPTY: main_ld = in_xfer;
            OCC_ONE: begin
                if (out_xfer) begin
                    main_ld   = in_xfer;
                    main_drop = !in_xfer;
                end else begin
                    skid_ld = in_xfer;
                end
            end
            OCC_FULL: begin
                if (out_xfer) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    skid_drop      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_data_d = main_from_skid ? skid_data : in_data;

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .ld_i    (main_ld),
        .drop_i  (main_drop),
        .ctrl_i  (main_ctrl_d),
        .data_i  (main_data_d),
        .valid_o (main_valid),
        .ctrl_o  (out_ctrl),
        .data_o  (out_data)
    );

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .ld_i    (skid_ld),
        .drop_i  (skid_drop),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    // Clear wins over increment; a stall cycle is one where main is blocked.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (main_valid && !out_ready && !hlt && !flush) begin
            stall_cnt_d = CNT_W'(sat_inc(64'(stall_cnt_q), CNT_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
